// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode and
// per-instruction execute paths, stalling on the memory ready handshake.
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_ld,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LW    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_SLTI_EX  = 4'd11,
        S_I_WB     = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state and Moore output decode; reset forces every output low.
    always_comb begin
        state_d       = S_FETCH;
        op_d          = op_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    op_d      = opcode;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_R:         state_d = S_R_EX;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        OP_SLTI:      state_d = S_SLTI_EX;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? S_WB_LW : S_MEM_RD;
                end
                S_WB_LW: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_I_WB;
                end
                S_SLTI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    state_d   = S_I_WB;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
        pc_ld = pc_write | (pc_write_cond & zero);
        state = rst ? '0 : STATE_W'(state_q);
    end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Main control FSM for the multicycle MIPS datapath. It fetches and decodes one instruction at a time and sequences the shared ALU, register file, PC and unified memory through per-instruction state paths. It drives the 2-bit `alu_op` consumed by the ALU function decoder. It also stalls on a memory ready handshake and reports instruction completion and illegal opcodes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE only.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if `zero`.
- `pc_ld`  out  1  `pc_write | (pc_write_cond & zero)`.
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `i_or_d`  out  1  0 PC address, 1 ALUOut address.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load.
- `reg_dst`  out  1  0 rt, 1 rd.
- `mem_to_reg`  out  1  0 ALUOut, 1 MDR.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  0 PC, 1 A.
- `alu_src_b`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded, 11 slt.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, slti 001010.
- All outputs are Moore decodes of `state`, except that `ir_write`/`pc_write` in FETCH and `instr_done` in MEM_WR are gated by `mem_ready`. Unlisted outputs are 0.
- State encodings and outputs:
  - FETCH=0: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready. Next state is DECODE if `mem_ready`, otherwise FETCH.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=00, which precomputes the branch target. Next state by opcode: lw/sw→MEM_ADDR, R→R_EX, beq→BEQ, j→JUMP, addi→ADDI_EX, slti→SLTI_EX. Any other opcode pulses illegal_op=1 and instr_done=1, and the next state is FETCH.
  - MEM_ADDR=2: alu_src_a=1, alu_src_b=10, alu_op=00. lw→MEM_RD, sw→MEM_WR. The opcode is held in an internal register latched in DECODE.
  - MEM_RD=3: mem_read=1, i_or_d=1. Next state is WB_LW on `mem_ready`, otherwise MEM_RD.
  - WB_LW=4: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state is FETCH.
  - MEM_WR=5: mem_write=1, i_or_d=1. Next state is FETCH with instr_done=1 on `mem_ready`, otherwise MEM_WR.
  - R_EX=6: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is R_WB.
  - R_WB=7: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
  - BEQ=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. Next state is FETCH.
  - JUMP=9: pc_write=1, pc_src=10, instr_done=1. Next state is FETCH.
  - ADDI_EX=10: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is I_WB.
  - SLTI_EX=11: alu_src_a=1, alu_src_b=10, alu_op=11. Next state is I_WB.
  - I_WB=12: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- Encodings 13–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.

## Timing
- Reset: an edge with `rst`=1 sets the state to FETCH and clears the latched opcode. While `rst`=1, every output is forced to 0, including `state`, which reads 0.
- Reset overrides everything, including mid-instruction and mid-stall. No memory strobe or write strobe is issued in any cycle where `rst`=1.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, addi, slti: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. While stalled, all strobes are held stable.
- `opcode` is ignored outside DECODE.
- `zero` affects only `pc_ld`, and only in BEQ.

## Test plan
- Reset, then R-type (opcode 000000) with `mem_ready`=1:
  - States follow 0,1,6,7,0.
  - alu_op=10 in R_EX.
  - reg_write=reg_dst=1 in R_WB.
  - instr_done pulses only on cycle 4.
- lw with `mem_ready` low for 2 cycles in MEM_RD:
  - States follow 0,1,2,3,3,3,4,0.
  - mem_read and i_or_d stay 1 for all 3 MEM_RD cycles.
  - mem_to_reg=1 in WB_LW.
- beq with zero=1, then beq with zero=0:
  - pc_ld=1 in BEQ for the first and 0 for the second.
  - alu_op=01 in both.
  - Each instruction takes 3 cycles.
- slti (001010) followed by addi (001000):
  - alu_op=11 in SLTI_EX and 00 in ADDI_EX.
  - Both have alu_src_b=10.
  - Both reach I_WB with reg_write=1 and reg_dst=0.
- Opcode 111111 gives illegal_op=instr_done=1 for one cycle in DECODE and returns to FETCH. Separately, a FETCH stall with `mem_ready`=0 for 3 cycles holds ir_write=pc_write=0 until `mem_ready` rises.
- Assert rst mid-MEM_WR while mem_write=1:
  - All outputs are 0 during rst.
  - The state is FETCH on the cycle after rst deasserts.
  - No mem_write is issued after reset.
